// File: rtl/max_tracker_pipe_pkg.sv
// Shared candidate type, tie-break encodings and helpers for max_tracker_pipe.
// Candidate fields are sized for the widest supported score/index widths.
package max_tracker_pipe_pkg;

  localparam int CAND_SCORE_W = 32;
  localparam int CAND_IDX_W   = 16;

  localparam int TIE_EARLIEST = 0;
  localparam int TIE_ROW_COL  = 1;

  typedef struct packed {
    logic [CAND_SCORE_W-1:0] score;
    logic [CAND_IDX_W-1:0]   row;
    logic [CAND_IDX_W-1:0]   col;
    logic                    found;
  } cand_t;

  function automatic int log4(input int n);
    int d = 0;
    for (int v = n; v > 1; v = v / 4) d++;
    return d;
  endfunction

  // True when a should displace b; equal keys keep b, so earlier candidates win.
  function automatic logic cand_beats(input cand_t a, input cand_t b, input int tie_mode);
    if (!a.found) return 1'b0;
    if (!b.found) return 1'b1;
    if (a.score != b.score) return a.score > b.score;
    return (tie_mode == TIE_ROW_COL) && ({a.row, a.col} < {b.row, b.col});
  endfunction

endpackage

// File: rtl/max_tree_node.sv
// Combinational 4-way compare node of the max_tracker_pipe reduction tree.
// Inputs are in ascending lane order; the result is all-zero when nothing is found.
module max_tree_node
  import max_tracker_pipe_pkg::*;
#(
  parameter int TIE_MODE = TIE_EARLIEST
) (
  input  cand_t c0,
  input  cand_t c1,
  input  cand_t c2,
  input  cand_t c3,
  output cand_t win
);

  always_comb begin
    win = '0;
    if (cand_beats(c0, win, TIE_MODE)) win = c0;
    if (cand_beats(c1, win, TIE_MODE)) win = c1;
    if (cand_beats(c2, win, TIE_MODE)) win = c2;
    if (cand_beats(c3, win, TIE_MODE)) win = c3;
  end

endmodule

// File: rtl/max_tracker_pipe.sv
// Pipelined running-maximum tracker: radix-4 registered compare tree feeding an
// alignment-scoped accumulator. Optional MAX_THRESH_EN adds score thresholding and hit_cnt.
module max_tracker_pipe
  import max_tracker_pipe_pkg::*;
#(
  parameter int SCORE_W  = 16,
  parameter int ROW_W    = 8,
  parameter int COL_W    = 8,
  parameter int LANES    = 64,
  parameter int TIE_MODE = TIE_EARLIEST,
  parameter int CNT_W    = 12
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            in_valid,
  input  logic                            in_first,
  input  logic                            in_last,
  input  logic [LANES-1:0]                lane_valid,
  input  logic [LANES-1:0][SCORE_W-1:0]   score_in,
  input  logic [LANES-1:0][ROW_W-1:0]     row_in,
  input  logic [LANES-1:0][COL_W-1:0]     col_in,
`ifdef MAX_THRESH_EN
  input  logic [SCORE_W-1:0]              thresh,
  output logic [CNT_W-1:0]                hit_cnt,
`endif
  output logic [SCORE_W-1:0]              max_score,
  output logic [ROW_W-1:0]                max_row,
  output logic [COL_W-1:0]                max_col,
  output logic                            max_found,
  output logic                            out_valid,
  output logic                            busy
);

  localparam int D  = log4(LANES);
  localparam int NW = LANES / 4;

  logic [LANES-1:0] lane_en;
  cand_t            lane_c [LANES];
  cand_t            node_c [D][NW];
  cand_t            stg_q  [D][NW];
  logic [D-1:0]     v_q, f_q, l_q;

`ifdef MAX_THRESH_EN
  always_comb begin
    for (int i = 0; i < LANES; i++) lane_en[i] = lane_valid[i] && (score_in[i] >= thresh);
  end
`else
  assign lane_en = lane_valid;
`endif

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_c[i].score = CAND_SCORE_W'(score_in[i]);
      lane_c[i].row   = CAND_IDX_W'(row_in[i]);
      lane_c[i].col   = CAND_IDX_W'(col_in[i]);
      lane_c[i].found = lane_en[i];
    end
  end

  // Level k holds LANES/4^(k+1) live nodes; the rest of each row is tied off.
  for (genvar k = 0; k < D; k++) begin : g_lvl
    localparam int N = LANES >> (2 * (k + 1));
    for (genvar j = 0; j < NW; j++) begin : g_node
      if (j < N) begin : g_used
        if (k == 0) begin : g_leaf
          max_tree_node #(.TIE_MODE(TIE_MODE)) u_node (
            .c0(lane_c[4*j]), .c1(lane_c[4*j+1]), .c2(lane_c[4*j+2]), .c3(lane_c[4*j+3]),
            .win(node_c[k][j])
          );
        end else begin : g_inner
          max_tree_node #(.TIE_MODE(TIE_MODE)) u_node (
            .c0(stg_q[k-1][4*j]), .c1(stg_q[k-1][4*j+1]),
            .c2(stg_q[k-1][4*j+2]), .c3(stg_q[k-1][4*j+3]),
            .win(node_c[k][j])
          );
        end
      end else begin : g_pad
        assign node_c[k][j] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      f_q <= '0;
      l_q <= '0;
      for (int k = 0; k < D; k++)
        for (int j = 0; j < NW; j++) stg_q[k][j] <= '0;
    end else begin
      for (int k = 0; k < D; k++)
        for (int j = 0; j < NW; j++) stg_q[k][j] <= node_c[k][j];
      v_q[0] <= in_valid & ~clear;
      f_q[0] <= in_first;
      l_q[0] <= in_last;
      for (int k = 1; k < D; k++) begin
        v_q[k] <= v_q[k-1] & ~clear;
        f_q[k] <= f_q[k-1];
        l_q[k] <= l_q[k-1];
      end
    end
  end

  cand_t win_d, acc_q, acc_nx;
  logic  v_d, f_d, l_d, open_q, open_nx;

  assign win_d = stg_q[D-1][0];
  assign v_d   = v_q[D-1];
  assign f_d   = f_q[D-1];
  assign l_d   = l_q[D-1];

  always_comb begin
    acc_nx  = acc_q;
    open_nx = open_q;
    if (v_d) begin
      if (f_d) begin
        acc_nx  = win_d;
        open_nx = 1'b1;
      end else if (open_q && cand_beats(win_d, acc_q, TIE_MODE)) begin
        acc_nx = win_d;
      end
      if (l_d) open_nx = 1'b0;
    end
  end

  // clear outranks a closing beat at the tree output: no pulse, outputs held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      open_q    <= 1'b0;
      out_valid <= 1'b0;
      max_score <= '0;
      max_row   <= '0;
      max_col   <= '0;
      max_found <= 1'b0;
    end else if (clear) begin
      acc_q     <= '0;
      open_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      acc_q     <= acc_nx;
      open_q    <= open_nx;
      out_valid <= v_d & l_d;
      if (v_d & l_d) begin
        max_score <= acc_nx.score[SCORE_W-1:0];
        max_row   <= acc_nx.row[ROW_W-1:0];
        max_col   <= acc_nx.col[COL_W-1:0];
        max_found <= acc_nx.found;
      end
    end
  end

  assign busy = (|v_q) | open_q;

`ifdef MAX_THRESH_EN
  localparam int PC_W = $clog2(LANES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PC_W-1:0]  pc_in;
  logic [PC_W-1:0]  pc_q [D];
  logic [CNT_W-1:0] hit_acc_q, hit_acc_nx;
  logic [31:0]      hit_sum;

  always_comb begin
    pc_in = '0;
    for (int i = 0; i < LANES; i++) pc_in = pc_in + PC_W'(lane_en[i]);
  end

  always_comb begin
    hit_sum    = 32'(hit_acc_q) + 32'(pc_q[D-1]);
    hit_acc_nx = hit_acc_q;
    if (v_d) begin
      if (f_d)
        hit_acc_nx = (32'(pc_q[D-1]) > 32'(CNT_MAX)) ? CNT_MAX : CNT_W'(pc_q[D-1]);
      else if (open_q)
        hit_acc_nx = (hit_sum > 32'(CNT_MAX)) ? CNT_MAX : CNT_W'(hit_sum);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < D; k++) pc_q[k] <= '0;
      hit_acc_q <= '0;
      hit_cnt   <= '0;
    end else begin
      pc_q[0] <= pc_in;
      for (int k = 1; k < D; k++) pc_q[k] <= pc_q[k-1];
      if (clear) begin
        hit_acc_q <= '0;
      end else begin
        hit_acc_q <= hit_acc_nx;
        if (v_d & l_d) hit_cnt <= hit_acc_nx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_max_tracker_pipe.sv
// Self-checking bench for max_tracker_pipe: one DUT per tie mode, a table of single-beat
// alignments, hand sequences for multi-cycle corners, and a random run against a scoreboard.
module tb_max_tracker_pipe;

  localparam int SW = 16, RW = 8, CW = 8, L = 64, D = 3, CNTW = 12;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic [L-1:0]         lane_valid = '0;
  logic [L-1:0][SW-1:0] score_in = '0;
  logic [L-1:0][RW-1:0] row_in = '0;
  logic [L-1:0][CW-1:0] col_in = '0;

  logic [SW-1:0] o_sc [2];
  logic [RW-1:0] o_rw [2];
  logic [CW-1:0] o_cl [2];
  logic          o_fd [2], o_ov [2], o_busy [2];
`ifdef MAX_THRESH_EN
  logic [SW-1:0]   thresh = '0;
  logic [CNTW-1:0] o_hit [2];
`endif

  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  max_tracker_pipe #(.SCORE_W(SW), .ROW_W(RW), .COL_W(CW), .LANES(L), .TIE_MODE(0), .CNT_W(CNTW)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .lane_valid(lane_valid), .score_in(score_in), .row_in(row_in), .col_in(col_in),
`ifdef MAX_THRESH_EN
    .thresh(thresh), .hit_cnt(o_hit[0]),
`endif
    .max_score(o_sc[0]), .max_row(o_rw[0]), .max_col(o_cl[0]), .max_found(o_fd[0]),
    .out_valid(o_ov[0]), .busy(o_busy[0])
  );

  max_tracker_pipe #(.SCORE_W(SW), .ROW_W(RW), .COL_W(CW), .LANES(L), .TIE_MODE(1), .CNT_W(CNTW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .lane_valid(lane_valid), .score_in(score_in), .row_in(row_in), .col_in(col_in),
`ifdef MAX_THRESH_EN
    .thresh(thresh), .hit_cnt(o_hit[1]),
`endif
    .max_score(o_sc[1]), .max_row(o_rw[1]), .max_col(o_cl[1]), .max_found(o_fd[1]),
    .out_valid(o_ov[1]), .busy(o_busy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] cur_thr();
`ifdef MAX_THRESH_EN
    return thresh;
`else
    return '0;
`endif
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic                 first, last;
    logic [L-1:0]         en;
    logic [L-1:0][SW-1:0] sc;
    logic [L-1:0][RW-1:0] rw;
    logic [L-1:0][CW-1:0] cl;
    int                   due;
  } beat_t;

  beat_t q[$];
  int    cyc;
  logic [SW-1:0] m_sc [2], e_sc [2];
  logic [RW-1:0] m_rw [2], e_rw [2];
  logic [CW-1:0] m_cl [2], e_cl [2];
  logic          m_fd [2], e_fd [2];
  logic          m_open, e_ov;
  int            m_hit, e_hit;

  // Best enabled lane by score, then (mode 1) smaller row/col, then lower lane.
  function automatic void beat_win(input beat_t b, input int mode, output logic f,
                                   output logic [SW-1:0] s, output logic [RW-1:0] r,
                                   output logic [CW-1:0] c);
    f = 0; s = '0; r = '0; c = '0;
    for (int i = 0; i < L; i++) begin
      if (b.en[i] && (!f || b.sc[i] > s ||
          (mode == 1 && b.sc[i] == s && (b.rw[i] < r || (b.rw[i] == r && b.cl[i] < c))))) begin
        f = 1; s = b.sc[i]; r = b.rw[i]; c = b.cl[i];
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    beat_t b, nb;
    logic f;
    logic [SW-1:0] s;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    int cnt;
    if (!rst_n) begin
      q.delete();
      cyc = 0; m_open = 0; e_ov = 0; m_hit = 0; e_hit = 0;
      for (int m = 0; m < 2; m++) begin
        m_sc[m] = '0; m_rw[m] = '0; m_cl[m] = '0; m_fd[m] = 0;
        e_sc[m] = '0; e_rw[m] = '0; e_cl[m] = '0; e_fd[m] = 0;
      end
    end else begin
      cyc++;
      e_ov = 0;
      if (clear) begin
        q.delete();
        m_open = 0; m_hit = 0;
        for (int m = 0; m < 2; m++) begin
          m_sc[m] = '0; m_rw[m] = '0; m_cl[m] = '0; m_fd[m] = 0;
        end
      end else begin
        if (q.size() > 0 && q[0].due == cyc) begin
          b = q.pop_front();
          cnt = $countones(b.en);
          for (int m = 0; m < 2; m++) begin
            beat_win(b, m, f, s, r, c);
            if (b.first) begin
              m_fd[m] = f; m_sc[m] = s; m_rw[m] = r; m_cl[m] = c;
            end else if (m_open && f && (!m_fd[m] || s > m_sc[m] ||
                         (m == 1 && s == m_sc[m] && {r, c} < {m_rw[m], m_cl[m]}))) begin
              m_fd[m] = f; m_sc[m] = s; m_rw[m] = r; m_cl[m] = c;
            end
          end
          if (b.first) m_hit = (cnt > CNT_MAX) ? CNT_MAX : cnt;
          else if (m_open) m_hit = (m_hit + cnt > CNT_MAX) ? CNT_MAX : m_hit + cnt;
          if (b.first) m_open = 1;
          if (b.last) begin
            m_open = 0;
            e_ov = 1;
            e_hit = m_hit;
            for (int m = 0; m < 2; m++) begin
              e_sc[m] = m_sc[m]; e_rw[m] = m_rw[m]; e_cl[m] = m_cl[m]; e_fd[m] = m_fd[m];
            end
          end
        end
        if (in_valid) begin
          nb.first = in_first; nb.last = in_last;
          nb.sc = score_in; nb.rw = row_in; nb.cl = col_in;
          for (int i = 0; i < L; i++) nb.en[i] = lane_valid[i] && (score_in[i] >= cur_thr());
          nb.due = cyc + D;
          q.push_back(nb);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("sb_out_valid%0d", m), o_ov[m], e_ov);
        chk($sformatf("sb_score%0d", m), o_sc[m], e_sc[m]);
        chk($sformatf("sb_row%0d", m), o_rw[m], e_rw[m]);
        chk($sformatf("sb_col%0d", m), o_cl[m], e_cl[m]);
        chk($sformatf("sb_found%0d", m), o_fd[m], e_fd[m]);
        chk($sformatf("sb_busy%0d", m), o_busy[m], (q.size() > 0) || m_open);
`ifdef MAX_THRESH_EN
        chk($sformatf("sb_hit%0d", m), o_hit[m], e_hit);
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_lanes();
    lane_valid = '0; score_in = '0; row_in = '0; col_in = '0;
  endtask

  task automatic put_lane(input int i, input int s, input int r, input int c);
    lane_valid[i] = 1'b1; score_in[i] = SW'(s); row_in[i] = RW'(r); col_in[i] = CW'(c);
  endtask

  task automatic set_beat(input logic first, input logic last);
    in_valid = 1'b1; in_first = first; in_last = last;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input int m, input logic ov, input int s,
                         input int r, input int c, input int f);
    chk({tag, "_valid"}, o_ov[m], ov);
    chk({tag, "_score"}, o_sc[m], s);
    chk({tag, "_row"}, o_rw[m], r);
    chk({tag, "_col"}, o_cl[m], c);
    chk({tag, "_found"}, o_fd[m], f);
  endtask

  typedef struct {
    int hot; int hs; int bound; bit masked;
    int es; int er; int ec; int ef;
  } vec_t;
  vec_t tbl [6];

  initial begin
    tbl[0] = '{10, 50, 50, 1'b0, 50, 10, 53, 1};
    tbl[1] = '{0, 1000, 100, 1'b0, 1000, 0, 63, 1};
    tbl[2] = '{63, 65535, 65535, 1'b0, 65535, 63, 0, 1};
    tbl[3] = '{5, 9, 9, 1'b1, 0, 0, 0, 0};
    tbl[4] = '{37, 5, 1, 1'b0, 5, 37, 26, 1};
    tbl[5] = '{0, 0, 1, 1'b0, 0, 0, 63, 1};

    #3;
    for (int m = 0; m < 2; m++) begin
      chk_out("reset", m, 1'b0, 0, 0, 0, 0);
      chk("reset_busy", o_busy[m], 0);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    // single-beat alignments
    for (int v = 0; v < 6; v++) begin
      clear_lanes();
      if (!tbl[v].masked)
        for (int i = 0; i < L; i++)
          put_lane(i, (i == tbl[v].hot) ? tbl[v].hs : (i * 13) % tbl[v].bound, i, 63 - i);
      set_beat(1'b1, 1'b1);
      step();
      idle(D);
      for (int m = 0; m < 2; m++)
        chk_out($sformatf("tbl%0d_m%0d", v, m), m, 1'b1, tbl[v].es, tbl[v].er, tbl[v].ec, tbl[v].ef);
    end

    // three-beat alignment, equal maxima in beats 2 and 3
    clear_lanes(); put_lane(5, 30, 20, 1); put_lane(6, 12, 0, 0);
    set_beat(1'b1, 1'b0); step();
    clear_lanes(); put_lane(3, 70, 40, 2); put_lane(4, 70, 45, 0); put_lane(7, 69, 1, 1);
    set_beat(1'b0, 1'b0); step();
    clear_lanes(); put_lane(2, 10, 0, 0); put_lane(9, 70, 12, 3);
    set_beat(1'b0, 1'b1); step();
    idle(D);
    chk_out("tie_m0", 0, 1'b1, 70, 40, 2, 1);
    chk_out("tie_m1", 1, 1'b1, 70, 12, 3, 1);

    // fully masked two-beat alignment
    clear_lanes();
    set_beat(1'b1, 1'b0); step();
    set_beat(1'b0, 1'b1); step();
    idle(D - 1);
    chk_out("hold_m0", 0, 1'b0, 70, 40, 2, 1);
    idle(1);
    chk_out("masked_m0", 0, 1'b1, 0, 0, 0, 0);
    chk_out("masked_m1", 1, 1'b1, 0, 0, 0, 0);

    // back-to-back alignments
    clear_lanes(); put_lane(0, 20, 1, 1);
    set_beat(1'b1, 1'b1); step();
    clear_lanes(); put_lane(1, 90, 2, 2);
    set_beat(1'b1, 1'b1); step();
    idle(D - 1);
    chk_out("b2b_a", 0, 1'b1, 20, 1, 1, 1);
    idle(1);
    chk_out("b2b_b", 0, 1'b1, 90, 2, 2, 1);

    // clear two cycles after a closing beat
    clear_lanes(); put_lane(4, 77, 3, 3);
    set_beat(1'b1, 1'b1); step();
    idle(1);
    clear = 1'b1; step();
    clear = 1'b0;
    for (int m = 0; m < 2; m++) chk("clear_busy", o_busy[m], 0);
    for (int t = 0; t < D + 2; t++) begin
      step();
      for (int m = 0; m < 2; m++) chk_out("clear_held", m, 1'b0, 90, 2, 2, 1);
    end

    // reset in the middle of an alignment
    clear_lanes(); put_lane(5, 123, 4, 4);
    set_beat(1'b1, 1'b0); step();
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk_out("midreset", m, 1'b0, 0, 0, 0, 0);
      chk("midreset_busy", o_busy[m], 0);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

`ifdef MAX_THRESH_EN
    thresh = SW'(40);
    clear_lanes();
    put_lane(0, 40, 0, 0); put_lane(1, 41, 1, 1); put_lane(2, 50, 2, 2);
    put_lane(3, 60, 3, 3); put_lane(4, 45, 4, 4);
    put_lane(5, 39, 5, 5); put_lane(6, 10, 6, 6); put_lane(7, 0, 7, 7);
    set_beat(1'b1, 1'b0); step();
    clear_lanes();
    put_lane(10, 55, 10, 10); put_lane(11, 42, 11, 11); put_lane(12, 40, 12, 12);
    put_lane(13, 44, 13, 13); put_lane(14, 59, 14, 14); put_lane(15, 39, 15, 15);
    set_beat(1'b0, 1'b1); step();
    idle(D);
    for (int m = 0; m < 2; m++) begin
      chk_out("thr", m, 1'b1, 60, 3, 3, 1);
      chk("thr_hit", o_hit[m], 10);
    end
    thresh = '0;
`endif

    // random traffic checked by the scoreboard
    for (int t = 0; t < 500; t++) begin
      int kind;
      kind = $urandom_range(0, 7);
      in_valid = ($urandom_range(0, 3) != 0);
      in_first = ($urandom_range(0, 4) == 0);
      in_last  = ($urandom_range(0, 4) == 0);
      clear    = ($urandom_range(0, 40) == 0);
      for (int i = 0; i < L; i++) begin
        lane_valid[i] = (kind == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
        score_in[i]   = (kind == 1) ? SW'($urandom) : SW'($urandom_range(0, 15));
        row_in[i]     = RW'($urandom_range(0, 3));
        col_in[i]     = CW'($urandom_range(0, 255));
      end
      step();
    end
    clear = 1'b0;
    idle(D + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/max_tracker_pipe.md
Name: max_tracker_pipe

Overview:
- Pipelined, parametrised running-maximum tracker for the alignment array.
- Each cycle it accepts one beat of LANES cell candidates (score, row, col), each with a per-lane valid mask.
- A registered radix-4 comparison tree reduces each beat to one winner. The winner folds into an alignment-scoped accumulator delimited by first/last flags.
- At the end of an alignment it publishes the best cell and its position to the traceback controller with a one-cycle valid pulse.

Parameters:
- SCORE_W, 16, candidate score width (unsigned)
- ROW_W, 8, row index width
- COL_W, 8, column index width
- LANES, 64, candidates per beat; must be a power of 4 and at least 4
- TIE_MODE, 0, 0 = earliest candidate wins ties; 1 = lexicographically smaller (row, col) wins ties
- CNT_W, 12, hit counter width (used only with MAX_THRESH_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort: drops the pipeline and the open accumulator
- in_valid  in  1  beat present
- in_first  in  1  beat opens a new alignment
- in_last  in  1  beat closes the alignment
- lane_valid  in  LANES  per-lane candidate mask
- score_in  in  LANES x SCORE_W  candidate scores
- row_in  in  LANES x ROW_W  candidate rows
- col_in  in  LANES x COL_W  candidate columns
- max_score  out  SCORE_W  final maximum score
- max_row  out  ROW_W  row of the maximum
- max_col  out  COL_W  column of the maximum
- max_found  out  1  at least one valid candidate was seen in the alignment
- out_valid  out  1  one-cycle result pulse
- busy  out  1  pipeline or accumulator holds live data

Behaviour:
- Reset: all outputs 0; pipeline valids, accumulator and its open flag cleared.
- No backpressure: one beat is accepted every cycle in_valid=1.
- Tree: D = log4(LANES) levels, each followed by a register. Every stage carries valid, first, last and found flags.
- Node compare:
  - An invalid input never wins.
  - Higher score wins.
  - On equal scores, TIE_MODE 0 picks the lower lane index; TIE_MODE 1 picks the smaller row, then the smaller col.
  - Node found = OR of its children's found flags.
- Accumulator, acting on the tree output (stage D):
  - valid & first: load the beat winner and its found flag; set open. A first arriving while open silently discards the prior alignment with no pulse.
  - valid & !first & open: replace when beat found and (acc not found, or score > acc score, or TIE_MODE=1 with equal score and smaller (row, col)).
  - valid & !first & !open: beat ignored.
  - valid & last (first & last in the same beat allowed): next cycle out_valid=1. Output registers take the post-update accumulator; open is cleared.
- Latency: beat with in_last at cycle t produces out_valid at t+D+1. Default LANES=64 gives D=3, so out_valid at t+4.
- Output hold: max_* and max_found hold until the next out_valid. A fully-masked alignment outputs score/row/col = 0 with max_found=0.
- busy = OR(stage valids) | open.
- clear:
  - Zeroes stage valids, open and the accumulator; outputs are held.
  - clear in the same cycle as in_valid drops that beat.
  - clear wins over a concurrent last at stage D, so no pulse is produced.
- Arithmetic: unsigned compares only, no saturation or wrap; indices pass through unchanged.

Optional Feature:
- Macro: MAX_THRESH_EN
- Enabled:
  - Adds input thresh (SCORE_W) and output hit_cnt (CNT_W).
  - Lanes with score_in < thresh are masked before the tree.
  - hit_cnt = per-alignment count of unmasked lanes (popcount per beat, pipelined alongside the tree). It saturates at 2^CNT_W-1 and is latched with out_valid.
  - Reset value 0; clear zeroes the running count.
- Disabled: ports absent; masking is lane_valid only.

Decomposition:
- Shared package: cand_t struct (score, row, col, found), TIE_MODE encodings, function log4 used to compute D.
- One sub-module, max_tree_node: combinational 4-input compare returning a cand_t, parametrised by TIE_MODE, instantiated per tree node.

Test Plan:
- Single beat with first=last=1, LANES=64, lane 10 score 50 and others 0-49 -> out_valid at t+4: score 50 with lane 10 row/col, found=1.
- Three-beat alignment with beat maxima 30, 70, 70 (second 70 at a smaller row) -> TIE_MODE 0 reports the beat-2 position; TIE_MODE 1 reports the smaller row.
- All lane_valid=0 for a two-beat alignment -> out_valid, score/row/col=0, found=0; previous results held until then.
- Back-to-back alignments A (max 20) and B (max 90, first in the cycle after A's last) -> two pulses one cycle apart, 20 then 90.
- clear asserted two cycles after a last beat -> no out_valid, busy=0 next cycle, outputs unchanged. rst_n low mid-alignment -> all outputs 0.
- MAX_THRESH_EN with thresh=40 and 5 lanes >=40 in each of 2 beats -> hit_cnt=10; max ignores lanes below 40.
